// File: rtl/rx_uart_cfg.sv
// rx_uart_cfg: oversampled UART receiver with 2-of-3 majority voting, optional parity and 1 or 2 stop bits.
// Define RX_UART_CFG_BREAK_DETECT_EN to report all-zero frames on rx_break instead of rx_ready.
module rx_uart_cfg #(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int BAUD_RATE     = 115200,
  parameter int OVERSAMPLING  = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy,
  output logic                 rx_break
);

  localparam int SAMPLE_RATE = BAUD_RATE * OVERSAMPLING;
  localparam int DIV_RAW     = (CLK_FREQUENCY + SAMPLE_RATE / 2) / SAMPLE_RATE;
  localparam int DIV         = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W        = $clog2(OVERSAMPLING);
  localparam int BIT_W       = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  PH_EARLY  = OS_W'(OVERSAMPLING / 2 - 1);
  localparam logic [OS_W-1:0]  PH_CENTRE = OS_W'(OVERSAMPLING / 2);
  localparam logic [OS_W-1:0]  PH_LATE   = OS_W'(OVERSAMPLING / 2 + 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sync;
  logic                 r_rx_prev;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [OS_W-1:0]      r_os_cnt;
  logic                 r_samp_early;
  logic                 r_samp_centre;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frm_err;

  logic w_rx;
  logic w_fall;
  logic w_tick;
  logic w_vote_now;
  logic w_vote;
  logic w_par_expect;
  logic w_frm_final;
  logic w_frame_end;
  logic w_break;

  assign w_rx         = r_sync[1];
  assign w_fall       = r_rx_prev & ~w_rx;
  assign w_tick       = (r_div_cnt == DIV_LAST);
  // The third sample is taken live, so the vote resolves on the late-phase tick itself.
  assign w_vote_now   = w_tick && (r_os_cnt == PH_LATE);
  assign w_vote       = (r_samp_early & r_samp_centre) | (r_samp_early & w_rx) | (r_samp_centre & w_rx);
  assign w_par_expect = (PARITY == 1) ? ~^r_shift : ^r_shift;
  assign w_frm_final  = r_frm_err | ~w_vote;
  assign w_frame_end  = (r_state == S_STOP) && w_vote_now && (r_stop_cnt == STOP_LAST);
  assign rx_busy      = (r_state != S_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], rx};
      r_rx_prev <= w_rx;
    end
  end

  // Baud tick generator; its phase restarts at the start edge so samples land mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt     <= '0;
      r_os_cnt      <= '0;
      r_samp_early  <= 1'b1;
      r_samp_centre <= 1'b1;
    end else if ((r_state == S_IDLE) && w_fall) begin
      r_div_cnt <= '0;
      r_os_cnt  <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_os_cnt  <= r_os_cnt + 1'b1;
      if (r_os_cnt == PH_EARLY)  r_samp_early  <= w_rx;
      if (r_os_cnt == PH_CENTRE) r_samp_centre <= w_rx;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

`ifdef RX_UART_CFG_BREAK_DETECT_EN
  logic r_all_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_all_zero <= 1'b1;
      rx_break   <= 1'b0;
    end else begin
      rx_break <= w_frame_end && w_break;
      if (r_state == S_IDLE) begin
        r_all_zero <= 1'b1;
      end else if (w_vote_now && (r_state inside {S_DATA, S_PAR, S_STOP})) begin
        r_all_zero <= r_all_zero & ~w_vote;
      end
    end
  end

  assign w_break = r_all_zero & ~w_vote;
`else
  assign w_break  = 1'b0;
  assign rx_break = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_stop_cnt    <= 1'b0;
      r_shift       <= '0;
      r_par_err     <= 1'b0;
      r_frm_err     <= 1'b0;
      rx_data       <= '0;
      rx_ready      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state    <= S_START;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
          end
        end
        S_START: begin
          if (w_vote_now) r_state <= w_vote ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (w_vote_now) begin
            r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) r_state <= (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          if (w_vote_now) begin
            r_par_err <= (w_vote != w_par_expect);
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_vote_now) begin
            if (r_stop_cnt != STOP_LAST) begin
              r_stop_cnt <= 1'b1;
              r_frm_err  <= w_frm_final;
            end else if (w_break) begin
              r_state <= S_WAIT_IDLE;
            end else begin
              // Frame completes at mid stop bit, leaving the back half free for the next start edge.
              rx_data       <= r_shift;
              rx_parity_err <= r_par_err;
              rx_frame_err  <= w_frm_final;
              rx_ready      <= 1'b1;
              r_state       <= w_frm_final ? S_WAIT_IDLE : S_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (w_rx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
